// File: rtl/reg_file_wb_pkg.sv
// Shared widths and dump FSM state encoding for the register-file write-back slice.
package reg_file_wb_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_SEND = 1'b1
  } dump_state_e;
endpackage

// File: rtl/reg_dump_ctrl.sv
// Streams every register out over a valid/ready port, one beat per index, in order.
module reg_dump_ctrl
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_rd_idx,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  dump_state_e           r_state;
  logic                  r_valid;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_next_addr = r_addr + ONE;
  // Look ahead to the index the next load edge will capture, so the beat holds pre-edge data.
  assign o_rd_idx    = (r_state == DUMP_SEND) ? w_next_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DUMP_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        DUMP_IDLE: begin
          if (i_start) begin
            r_state <= DUMP_SEND;
            r_addr  <= '0;
            r_data  <= i_rd_data;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        DUMP_SEND: begin
          if (r_valid && i_ready) begin
            if (r_addr == LAST_IDX) begin
              r_state <= DUMP_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_addr  <= '0;
            end else begin
              r_addr <= w_next_addr;
              r_data <= i_rd_data;
            end
          end
        end
        default: r_state <= DUMP_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
endmodule

// File: rtl/reg_file_wb.sv
// ALU operand register file: two combinational read ports, write-back with ZERO flag,
// and a non-blocking register dump port.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  ZERO_IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  ZFLAG,
  input  logic                  DUMP_START,
  output logic                  DUMP_VALID,
  input  logic                  DUMP_READY,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic                  DUMP_BUSY
);
  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NREGS];
  logic                  r_zflag;
  logic [ADDR_WIDTH-1:0] w_dump_rd_idx;
  logic [DATA_WIDTH-1:0] w_dump_rd_data;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_zflag <= 1'b0;
    end else if (WRITE) begin
      r_regs[INADDRESS] <= IN;
      r_zflag           <= ZERO_IN;
    end
  end

  assign OUT1           = r_regs[OUT1ADDRESS];
  assign OUT2           = r_regs[OUT2ADDRESS];
  assign ZFLAG          = r_zflag;
  assign w_dump_rd_data = r_regs[w_dump_rd_idx];

  reg_dump_ctrl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dump (
    .clk      (CLK),
    .rst_n    (RESET),
    .i_start  (DUMP_START),
    .i_ready  (DUMP_READY),
    .o_rd_idx (w_dump_rd_idx),
    .i_rd_data(w_dump_rd_data),
    .o_valid  (DUMP_VALID),
    .o_busy   (DUMP_BUSY),
    .o_addr   (DUMP_ADDR),
    .o_data   (DUMP_DATA)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed scenarios plus a randomized phase.
module tb_reg_file_wb;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN = '0;
  logic [2:0] INADDRESS = '0;
  logic       WRITE = 1'b0;
  logic       ZERO_IN = 1'b0;
  logic [2:0] OUT1ADDRESS = '0;
  logic [2:0] OUT2ADDRESS = '0;
  logic [7:0] OUT1, OUT2;
  logic       ZFLAG;
  logic       DUMP_START = 1'b0;
  logic       DUMP_VALID;
  logic       DUMP_READY = 1'b0;
  logic [2:0] DUMP_ADDR;
  logic [7:0] DUMP_DATA;
  logic       DUMP_BUSY;

  reg_file_wb #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .ZERO_IN(ZERO_IN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .ZFLAG(ZFLAG), .DUMP_START(DUMP_START),
    .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY), .DUMP_ADDR(DUMP_ADDR),
    .DUMP_DATA(DUMP_DATA), .DUMP_BUSY(DUMP_BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_beats = 0;

  // Reference model: register contents, flag, and dump progress.
  logic [7:0]  m_mem [8];
  logic        m_z;
  logic        m_busy;
  int unsigned m_idx;
  logic [10:0] exp_q [$];
  logic [7:0]  seen [8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_z    = 1'b0;
    m_busy = 1'b0;
    m_idx  = 0;
    exp_q.delete();
  endfunction

  function automatic void clear_seen();
    for (int i = 0; i < 8; i++) seen[i] = 8'hEE;
  endfunction

  // Apply the model effect of the coming edge using pre-edge state, then advance one cycle.
  task automatic tick();
    if (!m_busy && DUMP_START) begin
      m_busy = 1'b1;
      m_idx  = 0;
      exp_q.push_back({3'd0, m_mem[0]});
    end else if (m_busy && DUMP_READY) begin
      if (m_idx == 7) m_busy = 1'b0;
      else begin
        m_idx++;
        exp_q.push_back({3'(m_idx), m_mem[m_idx]});
      end
    end
    if (WRITE) begin
      m_mem[INADDRESS] = IN;
      m_z = ZERO_IN;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic z);
    WRITE = 1'b1; INADDRESS = a; IN = d; ZERO_IN = z;
    tick();
    WRITE = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && DUMP_BUSY; k++) tick();
    chk("dump_busy_falls", 32'(DUMP_BUSY), 32'd0);
  endtask

  // Monitor: a beat is accepted on the next rising edge when valid and ready are both high.
  always @(negedge CLK) begin
    if (RESET && DUMP_VALID && DUMP_READY) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr %0d data 0x%0h expected no beat", DUMP_ADDR, DUMP_DATA);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("beat_addr", 32'(DUMP_ADDR), 32'(e[10:8]));
        chk("beat_data", 32'(DUMP_DATA), 32'(e[7:0]));
      end
      seen[DUMP_ADDR] = DUMP_DATA;
      n_beats++;
    end
  end

  initial begin
    int unsigned b0;
    model_reset();
    clear_seen();
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #1;
    chk("rst_out1", 32'(OUT1), 32'h00);
    chk("rst_out2", 32'(OUT2), 32'h00);
    chk("rst_zflag", 32'(ZFLAG), 32'd0);
    chk("rst_valid", 32'(DUMP_VALID), 32'd0);
    chk("rst_busy", 32'(DUMP_BUSY), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Write then read
    wr(3'd3, 8'h5A, 1'b0);
    wr(3'd5, 8'h00, 1'b1);
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
    #1;
    chk("wr_out1", 32'(OUT1), 32'h5A);
    chk("wr_out2", 32'(OUT2), 32'h00);
    chk("wr_zflag", 32'(ZFLAG), 32'd1);

    // Same-cycle read/write: no bypass
    wr(3'd2, 8'h11, 1'b0);
    OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd2;
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h22; ZERO_IN = 1'b1;
    #1;
    chk("rw_before", 32'(OUT1), 32'h11);
    tick();
    chk("rw_after", 32'(OUT1), 32'h22);
    chk("rw_same_port2", 32'(OUT2), 32'h22);
    WRITE = 1'b0; IN = 8'hFF; ZERO_IN = 1'b0;
    tick();
    chk("nowrite_hold", 32'(OUT1), 32'h22);
    chk("nowrite_zflag", 32'(ZFLAG), 32'd1);

    // Full dump with READY high, extra START mid-dump
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i), 1'b0);
    clear_seen();
    b0 = n_beats;
    DUMP_READY = 1'b1; DUMP_START = 1'b1;
    tick();
    DUMP_START = 1'b0;
    chk("dump_busy_rises", 32'(DUMP_BUSY), 32'd1);
    tick(); tick();
    DUMP_START = 1'b1;
    tick();
    DUMP_START = 1'b0;
    wait_idle();
    tick(); tick();
    chk("dump_no_restart", 32'(DUMP_VALID), 32'd0);
    chk("dump_beat_count", n_beats - b0, 32'd8);
    for (int i = 0; i < 8; i++) chk("dump_seen", 32'(seen[i]), 32'(8'h10 + i));

    // Backpressure at beat 2 with concurrent writes
    clear_seen();
    DUMP_START = 1'b1;
    tick();
    DUMP_START = 1'b0;
    tick(); tick();
    DUMP_READY = 1'b0;
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h99;
    tick();
    chk("bp_data", 32'(DUMP_DATA), 32'h12);
    chk("bp_addr", 32'(DUMP_ADDR), 32'd2);
    INADDRESS = 3'd4; IN = 8'h77;
    tick();
    chk("bp_data", 32'(DUMP_DATA), 32'h12);
    WRITE = 1'b0;
    tick();
    chk("bp_data", 32'(DUMP_DATA), 32'h12);
    chk("bp_valid", 32'(DUMP_VALID), 32'd1);
    DUMP_READY = 1'b1;
    wait_idle();
    chk("bp_beat2", 32'(seen[2]), 32'h12);
    chk("bp_beat4", 32'(seen[4]), 32'h77);

    // Reset mid-dump at beat 5
    DUMP_START = 1'b1;
    tick();
    DUMP_START = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_addr", 32'(DUMP_ADDR), 32'd5);
    #1 RESET = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(DUMP_VALID), 32'd0);
    chk("mid_rst_busy", 32'(DUMP_BUSY), 32'd0);
    chk("mid_rst_addr", 32'(DUMP_ADDR), 32'd0);
    chk("mid_rst_data", 32'(DUMP_DATA), 32'd0);
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = 3'(2 * i); OUT2ADDRESS = 3'(2 * i + 1);
      #1;
      chk("mid_rst_reg", 32'(OUT1), 32'h00);
      chk("mid_rst_reg", 32'(OUT2), 32'h00);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    clear_seen();
    b0 = n_beats;
    DUMP_START = 1'b1;
    tick();
    DUMP_START = 1'b0;
    wait_idle();
    chk("post_rst_count", n_beats - b0, 32'd8);
    for (int i = 0; i < 8; i++) chk("post_rst_seen", 32'(seen[i]), 32'h00);

    // Randomized phase
    for (int c = 0; c < 400; c++) begin
      WRITE       = 1'($urandom_range(0, 1));
      INADDRESS   = 3'($urandom_range(0, 7));
      IN          = 8'($urandom_range(0, 255));
      ZERO_IN     = 1'($urandom_range(0, 1));
      DUMP_READY  = ($urandom_range(0, 9) < 7);
      DUMP_START  = ($urandom_range(0, 9) == 0);
      OUT1ADDRESS = 3'($urandom_range(0, 7));
      OUT2ADDRESS = 3'($urandom_range(0, 7));
      #1;
      chk("rnd_out1", 32'(OUT1), 32'(m_mem[OUT1ADDRESS]));
      chk("rnd_out2", 32'(OUT2), 32'(m_mem[OUT2ADDRESS]));
      chk("rnd_zflag", 32'(ZFLAG), 32'(m_z));
      tick();
    end
    WRITE = 1'b0; DUMP_START = 1'b0; DUMP_READY = 1'b1;
    wait_idle();
    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
